dot_chunk_seq: RTL and testbench
================================

Name: dot_chunk_seq

Overview:
- Sequences a long dot product through one shared `dot_general_int`-style datapath.
- Each job of LEN chunks (C elements per chunk) is streamed chunk by chunk; one chunk is issued per cycle when possible.
- Returned per-chunk (dp, scale) pairs are merged into a block-scaled accumulator with exponent alignment.
- The final result is presented on a valid/ready output. Sits between the operand fetch stream and the result writeback.

Parameters:
- DP_W, 24: width of the signed datapath result i_dp.
- ACC_W, 32: width of the signed accumulator and o_res; must be >= DP_W.
- LEN_W, 8: width of the job length (chunk count).
- DP_LAT, 2: fixed datapath latency in cycles from o_issue to i_dp/i_scale valid; must be >= 1.

Ports:
- i_clk  in  1  clock; all state on its rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_job_valid  in  1  job request.
- o_job_ready  out  1  high only in IDLE.
- i_job_len  in  LEN_W  number of chunks; sampled on job handshake.
- i_chunk_valid  in  1  operand chunk available at the datapath inputs.
- o_chunk_ready  out  1  controller accepts the chunk.
- o_issue  out  1  = i_chunk_valid & o_chunk_ready; datapath launch strobe.
- i_dp  in  DP_W  signed datapath result, valid DP_LAT cycles after o_issue.
- i_scale  in  8  unsigned scale paired with i_dp.
- o_res_valid  out  1  result available.
- i_res_ready  in  1  result consumer ready.
- o_res  out  ACC_W  signed accumulated result.
- o_res_scale  out  8  scale of o_res.
- o_sat  out  1  at least one accumulate in this job saturated; valid with o_res_valid.

Behaviour:
- Reset (async assert, sync release):
  - State goes to IDLE.
  - Outputs: o_job_ready=1, o_chunk_ready=0, o_issue=0, o_res_valid=0, o_res=0, o_res_scale=0, o_sat=0.
  - Issue and receive counters are cleared, and the DP_LAT-deep in-flight valid shift register is cleared.
  - Any results still in flight are discarded. Reset mid-job aborts the job with no output.
- States:
  - IDLE: on job handshake, latch len and clear acc, scale, sat and both counters.
    - len != 0 → RUN.
    - len == 0 → DONE with o_res=0, o_res_scale=0, so o_res_valid rises the cycle after acceptance.
  - RUN: o_chunk_ready = (issued < len). Each o_issue increments issued. When issued reaches len → DRAIN, or → DONE directly if all results were already received that cycle.
  - DRAIN: o_chunk_ready=0; wait until received == len → DONE.
  - DONE: o_res_valid=1; o, o_res, o_res_scale and o_sat are held stable while i_res_ready=0. Handshake → IDLE. A new job is accepted no earlier than the cycle after.
- In-flight tracking:
  - A DP_LAT shift register carries o_issue.
  - Its tail marks i_dp/i_scale valid; results return in order.
  - A result that returns in the same cycle as an issue is handled in that cycle; the two counters are independent.
- Accumulate, on each valid return:
  - received == 0: acc ← sign-extend(i_dp), scale ← i_scale.
  - Otherwise let d = |i_scale − scale| and sh = min(d, ACC_W−1).
    - Arithmetic-shift right by sh whichever operand has the smaller scale (truncation toward −inf).
    - Sum in ACC_W+1 bits, then saturate to [−2^(ACC_W−1), 2^(ACC_W−1)−1].
    - Set o_sat sticky if the sum was clipped.
    - New scale = max(i_scale, scale). Equal scales mean no shift.
- Throughput: one chunk per cycle. Job latency = len + DP_LAT cycles from first issue to o_res_valid, absent stalls.
- Chunk stalls (i_chunk_valid=0) only delay issue; they never corrupt the accumulator.
- o_res, o_res_scale and o_sat are registered outputs.

Test Plan:
- DP_LAT=2: len=1, chunk returns i_dp=100, i_scale=10 → o_res=100, o_res_scale=10, o_sat=0; o_res_valid rises 3 cycles after issue.
- len=2, returns (50,5) then (−20,5) → o_res=30, o_res_scale=5.
- len=2, returns (64,3) then (16,5) → acc shifted right by 2: 16+16 gives o_res=32, o_res_scale=5. Swapped order gives the same result.
- Override ACC_W=DP_W=8: len=2, returns (100,0) and (100,0) → o_res=127, o_sat=1. Next job with (1,0) → o_sat=0.
- len=0 → o_res_valid the cycle after the job handshake with o_res=0, o_res_scale=0. Hold i_res_ready=0 for 5 cycles → outputs stable and o_job_ready=0 throughout.
- len=4 with i_chunk_valid gaps; assert i_rst_n low after 2 issues → all outputs at reset values immediately. Late i_dp returns are ignored; a following len=1 job gives the correct result.

Source files
------------

// File: rtl/dot_chunk_seq.sv
// Chunked dot-product sequencer: issues operand chunks to a fixed-latency datapath and
// merges the returned (dp, scale) pairs into a saturating block-scaled accumulator.
module dot_chunk_seq #(
    parameter int unsigned DP_W   = 24,
    parameter int unsigned ACC_W  = 32,
    parameter int unsigned LEN_W  = 8,
    parameter int unsigned DP_LAT = 2
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_job_valid,
    output logic                    o_job_ready,
    input  logic [LEN_W-1:0]        i_job_len,
    input  logic                    i_chunk_valid,
    output logic                    o_chunk_ready,
    output logic                    o_issue,
    input  logic signed [DP_W-1:0]  i_dp,
    input  logic [7:0]              i_scale,
    output logic                    o_res_valid,
    input  logic                    i_res_ready,
    output logic signed [ACC_W-1:0] o_res,
    output logic [7:0]              o_res_scale,
    output logic                    o_sat
);

    localparam logic [7:0]              SH_MAX  = 8'(ACC_W - 1);
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                  state;
    logic [LEN_W-1:0]        len;
    logic [LEN_W-1:0]        issued;
    logic [LEN_W-1:0]        rcvd;
    logic signed [ACC_W-1:0] acc;
    logic [7:0]              scale;
    logic                    sat;
    logic [DP_LAT-1:0]       inflight;

    logic                    rx;
    logic [LEN_W-1:0]        issued_n;
    logic [LEN_W-1:0]        rcvd_n;
    logic signed [ACC_W-1:0] acc_n;
    logic [7:0]              scale_n;
    logic                    sat_n;
    logic signed [ACC_W-1:0] dp_ext;
    logic signed [ACC_W-1:0] a_op;
    logic signed [ACC_W-1:0] b_op;
    logic signed [ACC_W:0]   sum;
    logic [7:0]              d;
    logic [7:0]              sh;
    logic                    in_up;

    assign o_issue  = i_chunk_valid & o_chunk_ready;
    assign rx       = inflight[DP_LAT-1] & ((state == S_RUN) || (state == S_DRAIN));
    assign issued_n = issued + LEN_W'(o_issue);
    assign rcvd_n   = rcvd + LEN_W'(rx);
    assign dp_ext   = ACC_W'(i_dp);
    assign in_up    = (i_scale > scale);

    // Align the smaller-scale operand to the larger scale, add with one guard bit, saturate.
    always_comb begin
        acc_n   = acc;
        scale_n = scale;
        sat_n   = sat;
        d       = '0;
        sh      = '0;
        a_op    = acc;
        b_op    = dp_ext;
        sum     = '0;
        if (rx) begin
            if (rcvd == '0) begin
                acc_n   = dp_ext;
                scale_n = i_scale;
            end else begin
                d  = in_up ? (i_scale - scale) : (scale - i_scale);
                sh = (d > SH_MAX) ? SH_MAX : d;
                if (in_up) begin
                    a_op = acc >>> sh;
                end else begin
                    b_op = dp_ext >>> sh;
                end
                sum = (ACC_W+1)'(a_op) + (ACC_W+1)'(b_op);
                if (sum[ACC_W] != sum[ACC_W-1]) begin
                    acc_n = sum[ACC_W] ? ACC_MIN : ACC_MAX;
                    sat_n = 1'b1;
                end else begin
                    acc_n = sum[ACC_W-1:0];
                end
                scale_n = in_up ? i_scale : scale;
            end
        end
    end

    // Control FSM, counters, in-flight tracking and registered result outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= S_IDLE;
            len           <= '0;
            issued        <= '0;
            rcvd          <= '0;
            acc           <= '0;
            scale         <= '0;
            sat           <= 1'b0;
            inflight      <= '0;
            o_job_ready   <= 1'b1;
            o_chunk_ready <= 1'b0;
            o_res_valid   <= 1'b0;
            o_res         <= '0;
            o_res_scale   <= '0;
            o_sat         <= 1'b0;
        end else begin
            inflight[0] <= o_issue;
            for (int unsigned i = 1; i < DP_LAT; i++) begin
                inflight[i] <= inflight[i-1];
            end
            case (state)
                S_IDLE: begin
                    if (i_job_valid) begin
                        len         <= i_job_len;
                        issued      <= '0;
                        rcvd        <= '0;
                        acc         <= '0;
                        scale       <= '0;
                        sat         <= 1'b0;
                        o_job_ready <= 1'b0;
                        if (i_job_len == '0) begin
                            state       <= S_DONE;
                            o_res_valid <= 1'b1;
                            o_res       <= '0;
                            o_res_scale <= '0;
                            o_sat       <= 1'b0;
                        end else begin
                            state         <= S_RUN;
                            o_chunk_ready <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    issued        <= issued_n;
                    rcvd          <= rcvd_n;
                    acc           <= acc_n;
                    scale         <= scale_n;
                    sat           <= sat_n;
                    o_chunk_ready <= (issued_n != len);
                    if (issued_n == len) begin
                        if (rcvd_n == len) begin
                            state       <= S_DONE;
                            o_res_valid <= 1'b1;
                            o_res       <= acc_n;
                            o_res_scale <= scale_n;
                            o_sat       <= sat_n;
                        end else begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    rcvd  <= rcvd_n;
                    acc   <= acc_n;
                    scale <= scale_n;
                    sat   <= sat_n;
                    if (rcvd_n == len) begin
                        state       <= S_DONE;
                        o_res_valid <= 1'b1;
                        o_res       <= acc_n;
                        o_res_scale <= scale_n;
                        o_sat       <= sat_n;
                    end
                end
                S_DONE: begin
                    if (i_res_ready) begin
                        state       <= S_IDLE;
                        o_res_valid <= 1'b0;
                        o_job_ready <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dot_chunk_seq.sv
// Scoreboard bench for dot_chunk_seq: a default instance (u=0) and an 8-bit accumulator
// instance (u=1), each fed by a DP_LAT-deep datapath model driven from directed vectors.
module tb_dot_chunk_seq;

    localparam int unsigned DP_LAT = 2;

    typedef struct packed {
        logic [23:0] dp;
        logic [7:0]  sc;
    } ret_t;

    typedef struct packed {
        logic [31:0] res;
        logic [7:0]  sc;
        logic        sat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        job_valid   [2];
    logic        job_ready   [2];
    logic [7:0]  job_len     [2];
    logic        chunk_valid [2];
    logic        chunk_ready [2];
    logic        issue       [2];
    logic [7:0]  sc_in       [2];
    logic        res_valid   [2];
    logic        res_ready   [2];
    logic [31:0] res         [2];
    logic [7:0]  res_sc      [2];
    logic        sat         [2];
    logic [23:0] dp_a;
    logic [7:0]  dp_b;
    logic [7:0]  res_b;

    ret_t pipe [2][DP_LAT];
    ret_t t_pop [2];
    ret_t rq [2][$];
    exp_t exp_q [2][$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dot_chunk_seq u_a (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_job_valid(job_valid[0]), .o_job_ready(job_ready[0]), .i_job_len(job_len[0]),
        .i_chunk_valid(chunk_valid[0]), .o_chunk_ready(chunk_ready[0]), .o_issue(issue[0]),
        .i_dp(dp_a), .i_scale(sc_in[0]),
        .o_res_valid(res_valid[0]), .i_res_ready(res_ready[0]),
        .o_res(res[0]), .o_res_scale(res_sc[0]), .o_sat(sat[0])
    );

    dot_chunk_seq #(.DP_W(8), .ACC_W(8)) u_b (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_job_valid(job_valid[1]), .o_job_ready(job_ready[1]), .i_job_len(job_len[1]),
        .i_chunk_valid(chunk_valid[1]), .o_chunk_ready(chunk_ready[1]), .o_issue(issue[1]),
        .i_dp(dp_b), .i_scale(sc_in[1]),
        .o_res_valid(res_valid[1]), .i_res_ready(res_ready[1]),
        .o_res(res_b), .o_res_scale(res_sc[1]), .o_sat(sat[1])
    );

    assign res[1]   = 32'($signed(res_b));
    assign dp_a     = pipe[0][DP_LAT-1].dp;
    assign sc_in[0] = pipe[0][DP_LAT-1].sc;
    assign dp_b     = pipe[1][DP_LAT-1].dp[7:0];
    assign sc_in[1] = pipe[1][DP_LAT-1].sc;

    // Datapath model: each issue pops the next directed return and delays it DP_LAT cycles.
    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (issue[u] && rq[u].size() != 0) t_pop[u] = rq[u].pop_front();
            else t_pop[u] = '0;
            for (int s = DP_LAT - 1; s > 0; s--) pipe[u][s] <= pipe[u][s-1];
            pipe[u][0] <= t_pop[u];
        end
    end

    // Monitor: every result handshake is checked against the scoreboard.
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (res_valid[u] && res_ready[u]) begin
                checks++;
                if (exp_q[u].size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_result u%0d: got res=%0d scale=%0d sat=%0d, none expected",
                             u, $signed(res[u]), res_sc[u], sat[u]);
                end else begin
                    exp_t e;
                    e = exp_q[u].pop_front();
                    if (res[u] !== e.res || res_sc[u] !== e.sc || sat[u] !== e.sat) begin
                        errors++;
                        $display("FAIL result u%0d: got res=%0d scale=%0d sat=%0d, expected res=%0d scale=%0d sat=%0d",
                                 u, $signed(res[u]), res_sc[u], sat[u], $signed(e.res), e.sc, e.sat);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, $signed(got), $signed(want));
        end
    endtask

    task automatic push_ret(input int u, input int dp, input int sc);
        ret_t r;
        r.dp = 24'(dp);
        r.sc = 8'(sc);
        rq[u].push_back(r);
    endtask

    task automatic push_exp(input int u, input int rv, input int sc, input bit s);
        exp_t e;
        e.res = 32'(rv);
        e.sc  = 8'(sc);
        e.sat = s;
        exp_q[u].push_back(e);
    endtask

    task automatic check_reset(input int u);
        chk("rst_job_ready",   32'(job_ready[u]),   32'd1);
        chk("rst_chunk_ready", 32'(chunk_ready[u]), 32'd0);
        chk("rst_issue",       32'(issue[u]),       32'd0);
        chk("rst_res_valid",   32'(res_valid[u]),   32'd0);
        chk("rst_res",         res[u],              32'd0);
        chk("rst_res_scale",   32'(res_sc[u]),      32'd0);
        chk("rst_sat",         32'(sat[u]),         32'd0);
    endtask

    // Runs one job; exp_lat < 0 skips the latency check (first issue to o_res_valid,
    // or handshake to o_res_valid when len is zero).
    task automatic do_job(input int u, input int len, input bit gaps, input int hold, input int exp_lat);
        int  c, nis, fi, vr, held;
        bit  done;
        exp_t e;
        tick();
        job_valid[u] = 1'b1;
        job_len[u]   = 8'(len);
        c = 0;
        @(negedge clk);
        while (!job_ready[u] && c < 50) begin
            tick();
            @(negedge clk);
            c++;
        end
        if (!job_ready[u]) begin
            checks++; errors++;
            $display("FAIL job_accept_timeout u%0d: job_ready=0 after %0d cycles, expected 1", u, c);
            job_valid[u] = 1'b0;
            return;
        end
        tick();
        job_valid[u] = 1'b0;
        nis = 0; fi = -1; vr = -1; held = 0; done = 1'b0;
        for (c = 0; c < 300 && !done; c++) begin
            chunk_valid[u] = (nis < len) && !(gaps && (c % 3 == 1));
            res_ready[u]   = (held >= hold);
            @(negedge clk);
            if (issue[u]) begin
                if (fi < 0) fi = c;
                nis++;
            end
            if (res_valid[u]) begin
                if (vr < 0) vr = c;
                if (res_ready[u]) begin
                    done = 1'b1;
                end else begin
                    held++;
                    e = (exp_q[u].size() != 0) ? exp_q[u][0] : '0;
                    chk("hold_job_ready", 32'(job_ready[u]), 32'd0);
                    chk("hold_res",       res[u],            e.res);
                    chk("hold_res_scale", 32'(res_sc[u]),    32'(e.sc));
                    chk("hold_sat",       32'(sat[u]),       32'(e.sat));
                end
            end
            tick();
        end
        chunk_valid[u] = 1'b0;
        res_ready[u]   = 1'b0;
        if (!done) begin
            checks++; errors++;
            $display("FAIL job_timeout u%0d len=%0d: no result handshake, issued=%0d expected %0d", u, len, nis, len);
        end else if (exp_lat >= 0) begin
            chk("latency", 32'((fi < 0) ? vr : vr - fi), 32'(exp_lat));
        end
    endtask

    initial begin
        int c, nis;
        rst_n = 1'b1;
        for (int u = 0; u < 2; u++) begin
            job_valid[u] = 1'b0; job_len[u] = '0; chunk_valid[u] = 1'b0; res_ready[u] = 1'b0;
            for (int s = 0; s < DP_LAT; s++) pipe[u][s] = '0;
        end
        #1 rst_n = 1'b0;
        #1;
        check_reset(0);
        check_reset(1);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (2) tick();

        push_ret(0, 100, 10);              push_exp(0, 100, 10, 0); do_job(0, 1, 0, 0, 3);
        push_ret(0, 50, 5); push_ret(0, -20, 5); push_exp(0, 30, 5, 0); do_job(0, 2, 0, 0, 4);
        push_ret(0, 64, 3); push_ret(0, 16, 5);  push_exp(0, 32, 5, 0); do_job(0, 2, 0, 0, 4);
        push_ret(0, 16, 5); push_ret(0, 64, 3);  push_exp(0, 32, 5, 0); do_job(0, 2, 0, 0, -1);
        push_ret(0, -5, 0); push_ret(0, 0, 1);   push_exp(0, -3, 1, 0); do_job(0, 2, 0, 0, -1);
        push_ret(0, 1000, 0); push_ret(0, 7, 200); push_exp(0, 7, 200, 0); do_job(0, 2, 0, 0, -1);
        push_ret(0, 1, 0); push_ret(0, 2, 0); push_ret(0, 3, 0); push_exp(0, 6, 0, 0); do_job(0, 3, 1, 0, -1);
        push_exp(0, 0, 0, 0); do_job(0, 0, 0, 5, 0);

        push_ret(1, 100, 0); push_ret(1, 100, 0);   push_exp(1, 127, 0, 1);  do_job(1, 2, 0, 0, 4);
        push_ret(1, 1, 0);                          push_exp(1, 1, 0, 0);    do_job(1, 1, 0, 0, 3);
        push_ret(1, -100, 0); push_ret(1, -100, 0); push_exp(1, -128, 0, 1); do_job(1, 2, 0, 0, -1);
        push_ret(1, 100, 0); push_ret(1, 100, 0); push_ret(1, -100, 0); push_exp(1, 27, 0, 1);
        do_job(1, 3, 1, 0, -1);

        // Abort a gapped len=4 job after two issues; its late returns must be ignored.
        for (int k = 0; k < 4; k++) push_ret(0, 500 + k, 4);
        tick();
        job_valid[0] = 1'b1;
        job_len[0]   = 8'd4;
        tick();
        job_valid[0] = 1'b0;
        nis = 0;
        for (c = 0; c < 40 && nis < 2; c++) begin
            chunk_valid[0] = !(c % 2 == 1);
            @(negedge clk);
            if (issue[0]) nis++;
            tick();
        end
        chunk_valid[0] = 1'b0;
        chk("abort_issues", 32'(nis), 32'd2);
        rst_n = 1'b0;
        #1;
        check_reset(0);
        rq[0].delete();
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        chk("abort_no_result", 32'(res_valid[0]), 32'd0);
        push_ret(0, 7, 3); push_exp(0, 7, 3, 0); do_job(0, 1, 0, 0, 3);

        repeat (3) tick();
        chk("scoreboard_empty_u0", 32'(exp_q[0].size()), 32'd0);
        chk("scoreboard_empty_u1", 32'(exp_q[1].size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
